// File: rtl/truth_table_exerciser.sv
// Self-test sequencer/checker for the 3-input block F = A&~B | B&C: walks abc 0..7 and
// compares three DUT outputs to a golden table. Optional EXERCISER_STEP_EN adds manual stepping.
module truth_table_exerciser #(
  parameter int SETTLE_CYCLES = 2,
  parameter bit STOP_ON_FAIL  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       step,
  input  logic       f_struct_in,
  input  logic       f_func_in,
  input  logic       f_behav_in,
  output logic [2:0] abc_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       fail,
  output logic [2:0] fail_vector,
  output logic [2:0] fail_mask
);
  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE,
`ifdef EXERCISER_STEP_EN
    STEP_WAIT,
`endif
    FAIL
  } state_t;

  localparam logic [7:0] GOLDEN      = 8'hB8;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state, next;
  logic [3:0] cnt;
  logic [2:0] m;
  logic       golden_bit;
  logic       restart;

  assign golden_bit = GOLDEN[abc_out];
  assign m          = {f_struct_in, f_func_in, f_behav_in} ^ {3{golden_bit}};
  assign restart    = start && (state == IDLE || state == DONE || state == FAIL);

  always_comb begin
    next = state;
    case (state)
      IDLE, DONE, FAIL: if (start) next = SETTLE;
      SETTLE:           if (cnt == SETTLE_LAST) next = CHECK;
      CHECK: begin
        if (m != 3'b000 && STOP_ON_FAIL)
          next = FAIL;
        else if (abc_out == 3'd7)
          next = DONE;
        else
`ifdef EXERCISER_STEP_EN
          next = STEP_WAIT;
`else
          next = SETTLE;
`endif
      end
`ifdef EXERCISER_STEP_EN
      STEP_WAIT:        if (step) next = SETTLE;
`endif
      default:          next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      abc_out     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      fail_vector <= '0;
      fail_mask   <= '0;
    end else begin
      state <= next;
      if (restart) begin
        cnt         <= '0;
        abc_out     <= '0;
        busy        <= 1'b1;
        done        <= 1'b0;
        pass        <= 1'b0;
        fail        <= 1'b0;
        fail_vector <= '0;
        fail_mask   <= '0;
      end else begin
        case (state)
          SETTLE: cnt <= cnt + 4'd1;
          CHECK: begin
            cnt <= '0;
            // Only the first mismatching vector is recorded; the mask keeps accumulating.
            if (m != 3'b000 && !fail) fail_vector <= abc_out;
            fail_mask <= fail_mask | m;
            fail      <= fail | (m != 3'b000);
            if (next == DONE || next == FAIL) busy <= 1'b0;
            else if (next == SETTLE) abc_out <= abc_out + 3'd1;
          end
`ifdef EXERCISER_STEP_EN
          STEP_WAIT: if (step) abc_out <= abc_out + 3'd1;
`endif
          DONE: begin
            done <= 1'b1;
            pass <= ~fail;
          end
          FAIL: begin
            done <= 1'b1;
            pass <= 1'b0;
            fail <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_truth_table_exerciser.sv
// Scoreboard bench: two exercisers (halt-on-fail and run-all) driven from a reference F model
// with injectable faults; expected run results are queued at start and checked when done rises.
module tb_truth_table_exerciser;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, step = 1'b0;
  always #5 clk = ~clk;

  logic struct_inv = 1'b0, behav_zero = 1'b0;
  logic [2:0] a0, a1, fv0, fv1, fm0, fm1;
  logic busy0, done0, pass0, fail0, busy1, done1, pass1, fail1;
  logic s0, f0, b0, s1, f1, b1;

  function automatic logic fref(input logic [2:0] v);
    return (v[2] & ~v[1]) | (v[1] & v[0]);
  endfunction

  assign s0 = fref(a0) ^ struct_inv;
  assign f0 = fref(a0);
  assign b0 = behav_zero ? 1'b0 : fref(a0);
  assign s1 = fref(a1) ^ struct_inv;
  assign f1 = fref(a1);
  assign b1 = behav_zero ? 1'b0 : fref(a1);

  truth_table_exerciser #(.SETTLE_CYCLES(2), .STOP_ON_FAIL(1)) u0 (
    .clk(clk), .rst(rst), .start(start), .step(step),
    .f_struct_in(s0), .f_func_in(f0), .f_behav_in(b0),
    .abc_out(a0), .busy(busy0), .done(done0), .pass(pass0), .fail(fail0),
    .fail_vector(fv0), .fail_mask(fm0));

  truth_table_exerciser #(.SETTLE_CYCLES(2), .STOP_ON_FAIL(0)) u1 (
    .clk(clk), .rst(rst), .start(start), .step(step),
    .f_struct_in(s1), .f_func_in(f1), .f_behav_in(b1),
    .abc_out(a1), .busy(busy1), .done(done1), .pass(pass1), .fail(fail1),
    .fail_vector(fv1), .fail_mask(fm1));

  logic [12:0] st0, st1;
  assign st0 = {a0, busy0, done0, pass0, fail0, fv0, fm0};
  assign st1 = {a1, busy1, done1, pass1, fail1, fv1, fm1};

  typedef struct {
    logic       pass;
    logic       fail;
    logic [2:0] fv;
    logic [2:0] fm;
    logic [2:0] abc;
    int         lat;
  } exp_t;

  exp_t q0[$], q1[$];
  int errors = 0, checks = 0;
  int cyc = 0, sc0 = 0, sc1 = 0;

  function automatic exp_t mk(input logic p, input logic f, input logic [2:0] fv,
                              input logic [2:0] fm, input logic [2:0] abc, input int lat);
    exp_t e;
    e.pass = p; e.fail = f; e.fv = fv; e.fm = fm; e.abc = abc; e.lat = lat;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cmp_res(input string tag, input exp_t e, input logic [12:0] st, input int lat);
    chk({tag, "_pass"}, int'(st[7]), int'(e.pass));
    chk({tag, "_fail"}, int'(st[6]), int'(e.fail));
    chk({tag, "_fail_vector"}, int'(st[5:3]), int'(e.fv));
    chk({tag, "_fail_mask"}, int'(st[2:0]), int'(e.fm));
    chk({tag, "_abc"}, int'(st[12:10]), int'(e.abc));
    chk({tag, "_busy"}, int'(st[9]), 0);
    if (e.lat >= 0) chk({tag, "_latency"}, lat, e.lat);
  endtask

  // Start-sampling edge per DUT, used for latency measurement.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (start && !rst && !busy0) sc0 <= cyc + 1;
    if (start && !rst && !busy1) sc1 <= cyc + 1;
  end

  logic dp0 = 1'b0, dp1 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done0 && !dp0) begin
      if (q0.size() == 0) chk("u0_unexpected_done", 1, 0);
      else begin e = q0.pop_front(); cmp_res("u0", e, st0, cyc - sc0); end
    end
    if (done1 && !dp1) begin
      if (q1.size() == 0) chk("u1_unexpected_done", 1, 0);
      else begin e = q1.pop_front(); cmp_res("u1", e, st1, cyc - sc1); end
    end
    dp0 = done0;
    dp1 = done1;
  end

  task automatic go(input exp_t e0, input exp_t e1, input bit push);
    @(negedge clk);
    start = 1'b1;
    if (push) begin q0.push_back(e0); q1.push_back(e1); end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_both(input int lim);
    int n = 0;
    while (!(done0 && done1) && n < lim) begin @(negedge clk); n++; end
    chk("run_completes", int'(done0 && done1), 1);
    @(negedge clk);
  endtask

  exp_t ok;
  initial begin
    ok = mk(1'b1, 1'b0, 3'd0, 3'b000, 3'd7, 25);
    // Reset, with start held high to show reset dominates.
    start = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_u0", int'(st0), 0);
    chk("reset_u1", int'(st1), 0);
    start = 1'b0;
    rst = 1'b0;

    // Fault-free run: both pass in 25 cycles.
    go(ok, ok, 1'b1);
    chk("first_vector_abc", int'(a0), 0);
    wait_both(60);

    // f_behav stuck at 0: first mismatch at abc=3.
    behav_zero = 1'b1;
    go(mk(1'b0, 1'b1, 3'd3, 3'b001, 3'd3, 13), mk(1'b0, 1'b1, 3'd3, 3'b001, 3'd7, 25), 1'b1);
    wait_both(60);
    behav_zero = 1'b0;

    // f_struct inverted: every vector mismatches.
    struct_inv = 1'b1;
    go(mk(1'b0, 1'b1, 3'd0, 3'b100, 3'd0, 4), mk(1'b0, 1'b1, 3'd0, 3'b100, 3'd7, 25), 1'b1);
    wait_both(60);
    struct_inv = 1'b0;

    // Restart from DONE/FAIL clears status; starts mid-run are ignored.
    go(ok, ok, 1'b1);
    chk("restart_clear_u0", int'(st0), 13'h200);
    chk("restart_clear_u1", int'(st1), 13'h200);
`ifndef EXERCISER_STEP_EN
    step = 1'b1;
`endif
    repeat (3) begin
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    wait_both(60);
    step = 1'b0;

    // Reset mid-run at abc=4, with start asserted alongside.
    go(ok, ok, 1'b0);
    begin
      int n = 0;
      while (a0 != 3'd4 && n < 40) begin @(negedge clk); n++; end
    end
    chk("abort_reach_abc4", int'(a0), 4);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("abort_reset_u0", int'(st0), 0);
    chk("abort_reset_u1", int'(st1), 0);
    rst = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_stays_idle", int'(st0), 0);

`ifdef EXERCISER_STEP_EN
    // Manual stepping: holds at abc=0 until step pulses arrive.
    go(mk(1'b1, 1'b0, 3'd0, 3'b000, 3'd7, -1), mk(1'b1, 1'b0, 3'd0, 3'b000, 3'd7, -1), 1'b1);
    repeat (8) @(negedge clk);
    chk("step_hold_abc", int'(a0), 0);
    chk("step_hold_busy", int'(busy0), 1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0;
      repeat (4) @(negedge clk);
    end
    wait_both(20);
`endif

    chk("u0_queue_empty", q0.size(), 0);
    chk("u1_queue_empty", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
